coloring_checker: RTL and testbench

- Sequential, parametrised vertex-colouring validity checker. Generalises the fixed 3-vertex, 2-bit-colour combinational check to NV vertices with CW-bit colours.
- Colours are loaded into an internal register file. Edges then either stream in through a valid/ready handshake (arbitrary graph) or are enumerated internally over all vertex pairs (complete graph K_NV).
- The block reports a proper/improper verdict, a conflict count and the first conflicting edge. It sits beside the colouring engine as its on-chip result checker.

---
 rtl/coloring_checker_if.sv | 29 ++
 rtl/coloring_checker.sv | 170 +++++++++++++++++
 tb/tb_coloring_checker.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coloring_checker_if.sv
// Edge-stream bus for coloring_checker.
// Carries one graph edge (u, v) per accepted transfer.
//   edge_valid : master has an edge on edge_u/edge_v
//   edge_ready : checker accepts an edge this cycle
//   edge_u/v   : edge endpoints (vertex indices)
//   edge_last  : marks the final edge of the current check
// Handshake: a transfer happens on a rising clock edge where edge_valid and
// edge_ready are both high. The master holds edge_u/edge_v/edge_last stable
// while edge_valid is high and edge_ready is low. The checker never makes
// edge_ready depend on edge_valid.
interface coloring_checker_if #(
  parameter int VW = 3
) ();
  logic          edge_valid;
  logic          edge_ready;
  logic [VW-1:0] edge_u;
  logic [VW-1:0] edge_v;
  logic          edge_last;

  modport master (
    output edge_valid, edge_u, edge_v, edge_last,
    input  edge_ready
  );

  modport slave (
    input  edge_valid, edge_u, edge_v, edge_last,
    output edge_ready
  );
endinterface

// File: rtl/coloring_checker.sv
// Sequential vertex-colouring validity checker for NV vertices with CW-bit
// colours. Colours are loaded into a register file while idle. A check then
// either takes edges from the edge stream or walks every vertex pair of the
// complete graph K_NV. It reports a proper/improper verdict, a saturating
// conflict count and the first conflicting edge.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   color_we/addr/data : colour register write (IDLE only, addr>=NV ignored)
//   start, mode_complete : begin a check (IDLE only); 1 = K_NV, 0 = stream
//   edge_bus         : edge stream (slave side)
//   busy             : check in progress (STREAM or ENUM)
//   done             : one-cycle verdict strobe
//   proper           : no conflicts seen; holds until the next start
//   conflict_count   : saturating conflict counter
//   first_u/first_v  : endpoints of the first conflicting edge
//   range_err        : sticky, a streamed endpoint was >= NV
//   state_dbg        : current FSM state (IDLE=0, STREAM=1, ENUM=2, FIN=3)
module coloring_checker #(
  parameter int NV   = 8,
  parameter int CW   = 2,
  parameter int VW   = (NV > 2) ? $clog2(NV) : 1,
  parameter int CNTW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             color_we,
  input  logic [VW-1:0]    color_addr,
  input  logic [CW-1:0]    color_data,
  input  logic             start,
  input  logic             mode_complete,
  coloring_checker_if.slave edge_bus,
  output logic             busy,
  output logic             done,
  output logic             proper,
  output logic [CNTW-1:0]  conflict_count,
  output logic [VW-1:0]    first_u,
  output logic [VW-1:0]    first_v,
  output logic             range_err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_ENUM   = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] color_mem [NV];
  logic [VW-1:0] enum_i;
  logic [VW-1:0] enum_j;

  // Edge under evaluation this cycle: the streamed edge in STREAM, the pair
  // counters in ENUM.
  logic [VW-1:0]   eval_u;
  logic [VW-1:0]   eval_v;
  logic            eval_en;
  logic            eval_oor;
  logic            conflict;
  logic [CW-1:0]   color_u;
  logic [CW-1:0]   color_v;
  logic [CNTW-1:0] count_nxt;

  always_comb begin
    eval_u  = enum_i;
    eval_v  = enum_j;
    eval_en = 1'b0;
    if (state == S_STREAM) begin
      eval_u  = edge_bus.edge_u;
      eval_v  = edge_bus.edge_v;
      eval_en = edge_bus.edge_valid;
    end else if (state == S_ENUM) begin
      eval_en = 1'b1;
    end
  end

  // Colour lookup as an explicit mux so out-of-range indices read zero
  // instead of indexing past the register file.
  always_comb begin
    color_u = '0;
    color_v = '0;
    for (int k = 0; k < NV; k++) begin
      if (eval_u == VW'(k)) color_u = color_mem[k];
      if (eval_v == VW'(k)) color_v = color_mem[k];
    end
  end

  assign eval_oor = (int'(eval_u) >= NV) || (int'(eval_v) >= NV);
  assign conflict = eval_en &&
                    (eval_oor || (eval_u == eval_v) || (color_u == color_v));

  always_comb begin
    count_nxt = conflict_count;
    if (conflict && !(&conflict_count)) count_nxt = conflict_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      proper         <= 1'b0;
      conflict_count <= '0;
      first_u        <= '0;
      first_v        <= '0;
      range_err      <= 1'b0;
      enum_i         <= '0;
      enum_j         <= '0;
      for (int k = 0; k < NV; k++) color_mem[k] <= '0;
    end else begin
      if (eval_en) begin
        conflict_count <= count_nxt;
        // Count is zero only until the first conflict of a check, and it
        // never wraps, so this captures exactly the first one.
        if (conflict && (conflict_count == '0)) begin
          first_u <= eval_u;
          first_v <= eval_v;
        end
        if (eval_oor && (state == S_STREAM)) range_err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          // A write in the start cycle lands at the same edge the check
          // begins, so the first comparison already sees it.
          if (color_we) begin
            for (int k = 0; k < NV; k++) begin
              if (color_addr == VW'(k)) color_mem[k] <= color_data;
            end
          end
          if (start) begin
            proper         <= 1'b0;
            conflict_count <= '0;
            first_u        <= '0;
            first_v        <= '0;
            range_err      <= 1'b0;
            enum_i         <= '0;
            enum_j         <= VW'(1);
            state          <= mode_complete ? S_ENUM : S_STREAM;
          end
        end
        S_STREAM: begin
          if (edge_bus.edge_valid && edge_bus.edge_last) begin
            proper <= (count_nxt == '0);
            state  <= S_FIN;
          end
        end
        S_ENUM: begin
          if ((enum_i == VW'(NV-2)) && (enum_j == VW'(NV-1))) begin
            proper <= (count_nxt == '0);
            state  <= S_FIN;
          end else if (enum_j == VW'(NV-1)) begin
            enum_i <= enum_i + 1'b1;
            enum_j <= enum_i + VW'(2);
          end else begin
            enum_j <= enum_j + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign edge_bus.edge_ready = (state == S_STREAM);
  assign busy      = (state == S_STREAM) || (state == S_ENUM);
  assign done      = (state == S_FIN);
  assign state_dbg = state;

endmodule

// File: tb/tb_coloring_checker.sv
// Bench for coloring_checker with NV=6, CW=2, CNTW=3 (K_6 has 15 pairs, so
// the 3-bit counter saturation is reachable; indices 6 and 7 are encodable
// but out of range).
module tb_coloring_checker;
  localparam int NV   = 6;
  localparam int CW   = 2;
  localparam int CNTW = 3;
  localparam int VW   = 3;
  localparam int P    = NV * (NV - 1) / 2;
  localparam int RW   = 1 + CNTW + 2 * VW + 1;
  localparam int NEVER = 1 << 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            color_we;
  logic [VW-1:0]   color_addr;
  logic [CW-1:0]   color_data;
  logic            start;
  logic            mode_complete;
  logic            busy;
  logic            done;
  logic            proper;
  logic [CNTW-1:0] conflict_count;
  logic [VW-1:0]   first_u;
  logic [VW-1:0]   first_v;
  logic            range_err;
  logic [1:0]      state_dbg;

  coloring_checker_if #(.VW(VW)) edge_bus ();

  coloring_checker #(.NV(NV), .CW(CW), .VW(VW), .CNTW(CNTW)) dut (
    .clk            (clk),
    .rst            (rst),
    .color_we       (color_we),
    .color_addr     (color_addr),
    .color_data     (color_data),
    .start          (start),
    .mode_complete  (mode_complete),
    .edge_bus       (edge_bus),
    .busy           (busy),
    .done           (done),
    .proper         (proper),
    .conflict_count (conflict_count),
    .first_u        (first_u),
    .first_v        (first_v),
    .range_err      (range_err),
    .state_dbg      (state_dbg)
  );

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  int model_color [NV];
  int cur_u [$];
  int cur_v [$];
  logic [RW-1:0] exp_q [$];
  int exp_done_q [$];
  int busy_from = NEVER;
  int busy_to   = 0;
  bit stream_mode = 1'b0;

  // Verdict of a check over the edge list in cur_u/cur_v, straight from the
  // colouring rules: {proper, count, first_u, first_v, range_err}.
  function automatic logic [RW-1:0] model_verdict();
    int cnt = 0;
    int fu = 0;
    int fv = 0;
    bit rerr = 1'b0;
    for (int k = 0; k < cur_u.size(); k++) begin
      int u = cur_u[k];
      int v = cur_v[k];
      bit oor = (u >= NV) || (v >= NV);
      bit bad;
      bad = oor || (u == v);
      if (!oor && (model_color[u] == model_color[v])) bad = 1'b1;
      if (oor) rerr = 1'b1;
      if (bad) begin
        if (cnt == 0) begin
          fu = u;
          fv = v;
        end
        if (cnt < (1 << CNTW) - 1) cnt++;
      end
    end
    return {(cnt == 0), CNTW'(cnt), VW'(fu), VW'(fv), rerr};
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  bit            exp_done;
  bit            in_win;
  logic [RW-1:0] e;

  always @(negedge clk) begin
    exp_done = (exp_done_q.size() > 0) && (exp_done_q[0] == cyc);
    in_win   = (cyc >= busy_from) && (cyc < busy_to);
    chk("done", done, exp_done);
    chk("busy", busy, in_win);
    chk("edge_ready", edge_bus.edge_ready, stream_mode && in_win);
    if (exp_done) begin
      e = exp_q.pop_front();
      void'(exp_done_q.pop_front());
      chk("proper", proper, e[RW-1]);
      chk("conflict_count", conflict_count, e[2*VW+CNTW:2*VW+1]);
      chk("first_u", first_u, e[2*VW:VW+1]);
      chk("first_v", first_v, e[VW:1]);
      chk("range_err", range_err, e[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    color_we            = 1'b0;
    color_addr          = '0;
    color_data          = '0;
    start               = 1'b0;
    mode_complete       = 1'b0;
    edge_bus.edge_valid = 1'b0;
    edge_bus.edge_u     = '0;
    edge_bus.edge_v     = '0;
    edge_bus.edge_last  = 1'b0;
  endtask

  // Noise on inputs that must be ignored while a check is running.
  task automatic junk();
    color_we            = 1'($urandom_range(0, 1));
    color_addr          = VW'($urandom_range(0, 7));
    color_data          = CW'($urandom_range(0, 3));
    start               = 1'($urandom_range(0, 1));
    mode_complete       = 1'($urandom_range(0, 1));
    edge_bus.edge_valid = 1'($urandom_range(0, 1));
    edge_bus.edge_u     = VW'($urandom_range(0, 7));
    edge_bus.edge_v     = VW'($urandom_range(0, 7));
    edge_bus.edge_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic write_color(input int a, input int d);
    idle_inputs();
    color_we   = 1'b1;
    color_addr = VW'(a);
    color_data = CW'(d);
    if (a < NV) model_color[a] = d;
    tick();
    idle_inputs();
  endtask

  task automatic start_check(input bit complete, input bit with_we, input int a, input int d);
    idle_inputs();
    start         = 1'b1;
    mode_complete = complete;
    if (with_we) begin
      color_we   = 1'b1;
      color_addr = VW'(a);
      color_data = CW'(d);
      if (a < NV) model_color[a] = d;
    end
    stream_mode = !complete;
    busy_from   = cyc + 1;
    cur_u.delete();
    cur_v.delete();
    if (complete) begin
      for (int i = 0; i < NV; i++)
        for (int j = i + 1; j < NV; j++) begin
          cur_u.push_back(i);
          cur_v.push_back(j);
        end
      exp_q.push_back(model_verdict());
      exp_done_q.push_back(cyc + P + 1);
      busy_to = cyc + P + 1;
    end else begin
      busy_to = NEVER;
    end
    tick();
    idle_inputs();
  endtask

  task automatic run_complete(input bit with_we, input int a, input int d);
    start_check(1'b1, with_we, a, d);
    repeat (P) begin
      junk();
      tick();
    end
    idle_inputs();
    tick();
  endtask

  int plan_u [$];
  int plan_v [$];

  task automatic run_stream(input bit gaps);
    start_check(1'b0, 1'b0, 0, 0);
    for (int k = 0; k < plan_u.size(); k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          junk();
          edge_bus.edge_valid = 1'b0;
          tick();
        end
      end
      junk();
      edge_bus.edge_valid = 1'b1;
      edge_bus.edge_u     = VW'(plan_u[k]);
      edge_bus.edge_v     = VW'(plan_v[k]);
      edge_bus.edge_last  = (k == plan_u.size() - 1);
      cur_u.push_back(plan_u[k]);
      cur_v.push_back(plan_v[k]);
      if (k == plan_u.size() - 1) begin
        exp_q.push_back(model_verdict());
        exp_done_q.push_back(cyc + 1);
        busy_to = cyc + 1;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic set_colors(input int c0, input int c1, input int c2,
                            input int c3, input int c4, input int c5);
    write_color(0, c0);
    write_color(1, c1);
    write_color(2, c2);
    write_color(3, c3);
    write_color(4, c4);
    write_color(5, c5);
  endtask

  task automatic add_edge(input int u, input int v);
    plan_u.push_back(u);
    plan_v.push_back(v);
  endtask

  task automatic check_held(input string tag, input int p, input int cnt,
                            input int fu, input int fv, input int re);
    chk({tag, "_proper"}, proper, p);
    chk({tag, "_count"}, conflict_count, cnt);
    chk({tag, "_first_u"}, first_u, fu);
    chk({tag, "_first_v"}, first_v, fv);
    chk({tag, "_range_err"}, range_err, re);
  endtask

  task automatic rand_edge(output int u, output int v);
    u = ($urandom_range(0, 9) == 0) ? $urandom_range(NV, 7) : $urandom_range(0, NV - 1);
    v = ($urandom_range(0, 9) == 0) ? $urandom_range(NV, 7) : $urandom_range(0, NV - 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ru;
    int rv;
    for (int k = 0; k < NV; k++) model_color[k] = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", edge_bus.edge_ready, 0);
    check_held("reset", 0, 0, 0, 0, 0);
    tick();

    // Colours 0,1,2,0,1,2 on K_6: equal pairs (0,3),(1,4),(2,5).
    set_colors(0, 1, 2, 0, 1, 2);
    run_complete(1'b0, 0, 0);
    check_held("k6_pairs", 0, 3, 0, 3, 0);

    // Write in the start cycle: vertex 3 becomes colour 3, leaving (1,4),(2,5).
    run_complete(1'b1, 3, 3);
    check_held("k6_we_start", 0, 2, 1, 4, 0);

    // All colours equal: 15 conflicts saturate the 3-bit counter at 7.
    set_colors(0, 0, 0, 0, 0, 0);
    run_complete(1'b0, 0, 0);
    check_held("k6_sat", 0, 7, 0, 1, 0);

    // Stream with gaps, one self-loop (4,4).
    set_colors(0, 1, 2, 3, 0, 1);
    plan_u.delete();
    plan_v.delete();
    add_edge(0, 1);
    add_edge(1, 2);
    add_edge(2, 3);
    add_edge(4, 4);
    add_edge(3, 4);
    run_stream(1'b1);
    check_held("stream_self", 0, 1, 4, 4, 0);

    // Proper stream.
    plan_u.delete();
    plan_v.delete();
    add_edge(0, 1);
    add_edge(1, 2);
    add_edge(2, 3);
    run_stream(1'b0);
    check_held("stream_proper", 1, 0, 0, 0, 0);

    // Out-of-range endpoint.
    plan_u.delete();
    plan_v.delete();
    add_edge(0, 1);
    add_edge(2, 7);
    add_edge(1, 2);
    run_stream(1'b1);
    check_held("stream_range", 0, 1, 2, 7, 1);

    // Reset in the middle of a stream: no done, everything back to zero.
    start_check(1'b0, 1'b0, 0, 0);
    repeat (3) begin
      junk();
      edge_bus.edge_valid = 1'b1;
      edge_bus.edge_u     = 3'd5;
      edge_bus.edge_v     = 3'd7;
      edge_bus.edge_last  = 1'b0;
      tick();
    end
    idle_inputs();
    rst     = 1'b1;
    busy_to = cyc + 1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NV; k++) model_color[k] = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", edge_bus.edge_ready, 0);
    check_held("abort", 0, 0, 0, 0, 0);
    tick();
    // Colours were cleared by reset: (0,1) must now conflict.
    plan_u.delete();
    plan_v.delete();
    add_edge(0, 1);
    run_stream(1'b0);
    check_held("after_abort", 0, 1, 0, 1, 0);

    // Randomized checks against the model.
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(0, 4)) write_color($urandom_range(0, 7), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        run_complete(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3));
      end else begin
        plan_u.delete();
        plan_v.delete();
        repeat ($urandom_range(1, 10)) begin
          rand_edge(ru, rv);
          add_edge(ru, rv);
        end
        run_stream(1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
